// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache geometry: the configuration record and the helper
// that fills in the widths derived from it.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned LINE_WIDTH;
    int unsigned LINE_COUNT;
    int unsigned SET_COUNT;
    int unsigned FETCH_AW;
    int unsigned ID_WIDTH_REQ;
    int unsigned LINE_ALIGN;
    int unsigned COUNT_ALIGN;
    int unsigned SET_ALIGN;
    int unsigned TAG_WIDTH;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    LINE_WIDTH:   128,
    LINE_COUNT:   8,
    SET_COUNT:    2,
    FETCH_AW:     32,
    ID_WIDTH_REQ: 4,
    default:      0
  };

  // An all-zero configuration selects DEFAULT_CFG; derived widths are always
  // recomputed from the base geometry so callers only set the first five.
  function automatic config_t resolve_cfg(config_t cfg);
    config_t c;
    c = (cfg == '0) ? DEFAULT_CFG : cfg;
    c.LINE_ALIGN  = $clog2(c.LINE_WIDTH / 8);
    c.COUNT_ALIGN = $clog2(c.LINE_COUNT);
    c.SET_ALIGN   = (c.SET_COUNT > 1) ? $clog2(c.SET_COUNT) : 1;
    c.TAG_WIDTH   = c.FETCH_AW - c.LINE_ALIGN - c.COUNT_ALIGN;
    return c;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter: MODE 0 counts from bit 0 upward (index of the
// lowest set bit), MODE 1 from the MSB downward; empty_o flags an all-zero input.
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  logic found;

  always_comb begin
    found = 1'b0;
    cnt_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && in_i[MODE ? (WIDTH - 1 - i) : i]) begin
        found = 1'b1;
        cnt_o = CNT_WIDTH'(i);
      end
    end
    empty_o = ~found;
  end

endmodule

// File: rtl/snitch_icache_refill_handler.sv
// Miss handling for the instruction cache: tracks outstanding line refills,
// merges duplicate misses, writes returning lines and answers all waiters.
module snitch_icache_refill_handler
  import snitch_icache_pkg::*;
#(
  parameter config_t     CFG           = '0,
  parameter int unsigned PENDING_COUNT = 2,
  localparam config_t     C          = resolve_cfg(CFG),
  localparam int unsigned AW         = C.FETCH_AW,
  localparam int unsigned LINE_W     = C.LINE_WIDTH,
  localparam int unsigned ID_W       = C.ID_WIDTH_REQ,
  localparam int unsigned SET_AW     = C.SET_ALIGN,
  localparam int unsigned COUNT_AW   = C.COUNT_ALIGN,
  localparam int unsigned TAG_W      = C.TAG_WIDTH,
  localparam int unsigned LINE_ALIGN = C.LINE_ALIGN,
  localparam int unsigned RID_W      = (PENDING_COUNT > 1) ? $clog2(PENDING_COUNT) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              flush_valid_i,
  output logic              flush_ready_o,

  input  logic [AW-1:0]     in_addr_i,
  input  logic [ID_W-1:0]   in_id_i,
  input  logic [SET_AW-1:0] in_set_i,
  input  logic              in_hit_i,
  input  logic              in_error_i,
  input  logic [LINE_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,

  output logic [LINE_W-1:0] rsp_data_o,
  output logic              rsp_error_o,
  output logic [ID_W-1:0]   rsp_id_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,

  output logic [COUNT_AW-1:0] write_addr_o,
  output logic [SET_AW-1:0]   write_set_o,
  output logic [LINE_W-1:0]   write_data_o,
  output logic [TAG_W-1:0]    write_tag_o,
  output logic                write_error_o,
  output logic                write_valid_o,
  input  logic                write_ready_i,

  output logic [AW-1:0]     refill_addr_o,
  output logic [RID_W-1:0]  refill_id_o,
  output logic              refill_valid_o,
  input  logic              refill_ready_i,

  input  logic [LINE_W-1:0] refill_data_i,
  input  logic              refill_error_i,
  input  logic [RID_W-1:0]  refill_id_i,
  input  logic              refill_rsp_valid_i,
  output logic              refill_rsp_ready_o
);

  localparam int unsigned LINE_IDX_W = AW - LINE_ALIGN;
  localparam logic [SET_AW-1:0] VICTIM_LAST = SET_AW'(C.SET_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RESPOND
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [LINE_IDX_W-1:0] line;
    logic [ID_W-1:0]       mask;
  } entry_t;

  entry_t entries_q [PENDING_COUNT];

  state_e             state_q, state_d;
  logic [RID_W-1:0]   rid_q;
  logic [SET_AW-1:0]  victim_q;

  logic [LINE_IDX_W-1:0]    line_in;
  logic [PENDING_COUNT-1:0] valid_vec, match_vec;
  logic [RID_W-1:0]         free_idx;
  logic                     table_full;
  logic                     is_hit, merge, flush_block, alloc_ok;
  logic                     do_alloc, do_merge, do_free, victim_adv;
  entry_t                   cur_entry;
  logic                     unused_set;

  assign unused_set = ^in_set_i;
  assign line_in    = in_addr_i[AW-1:LINE_ALIGN];
  assign cur_entry  = entries_q[rid_q];

  always_comb begin
    valid_vec = '0;
    match_vec = '0;
    for (int unsigned i = 0; i < PENDING_COUNT; i++) begin
      valid_vec[i] = entries_q[i].valid;
      match_vec[i] = entries_q[i].valid && (entries_q[i].line == line_in);
    end
  end

  lzc #(
    .WIDTH (PENDING_COUNT),
    .MODE  (1'b0)
  ) i_free_lzc (
    .in_i    (~valid_vec),
    .cnt_o   (free_idx),
    .empty_o (table_full)
  );

  assign flush_ready_o = ~(|valid_vec) && (state_q == IDLE);
  assign refill_addr_o = {line_in, {LINE_ALIGN{1'b0}}};
  assign refill_id_o   = free_idx;

  assign write_addr_o  = cur_entry.line[COUNT_AW-1:0];
  assign write_tag_o   = cur_entry.line[LINE_IDX_W-1:COUNT_AW];
  assign write_set_o   = victim_q;
  assign write_data_o  = refill_data_i;
  assign write_error_o = refill_error_i;

  // Lookup side. Misses are accepted in IDLE and WRITE (merge or allocate);
  // RESPOND owns the response channel, so the lookup port stalls there.
  always_comb begin
    is_hit         = in_hit_i | in_error_i;
    merge          = |match_vec;
    flush_block    = flush_valid_i & ~flush_ready_o;
    alloc_ok       = ~table_full & ~flush_block & (state_q != RESPOND);
    in_ready_o     = 1'b0;
    refill_valid_o = 1'b0;
    do_alloc       = 1'b0;
    do_merge       = 1'b0;
    if (state_q != RESPOND) begin
      if (is_hit) begin
        in_ready_o = (state_q == IDLE) & rsp_ready_i;
      end else if (merge) begin
        in_ready_o = 1'b1;
        do_merge   = in_valid_i;
      end else if (alloc_ok) begin
        refill_valid_o = in_valid_i;
        in_ready_o     = refill_ready_i;
        do_alloc       = in_valid_i & refill_ready_i;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    refill_rsp_ready_o = 1'b0;
    write_valid_o      = 1'b0;
    rsp_valid_o        = 1'b0;
    rsp_data_o         = '0;
    rsp_error_o        = 1'b0;
    rsp_id_o           = '0;
    do_free            = 1'b0;
    victim_adv         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i && is_hit) begin
          rsp_valid_o = 1'b1;
          rsp_data_o  = in_data_i;
          rsp_error_o = in_error_i;
          rsp_id_o    = in_id_i;
        end
        if (refill_rsp_valid_i) begin
          if (valid_vec[refill_id_i]) state_d = WRITE;
          else                        refill_rsp_ready_o = 1'b1;
        end
      end
      WRITE: begin
        write_valid_o = 1'b1;
        if (write_ready_i) begin
          state_d    = RESPOND;
          victim_adv = 1'b1;
        end
      end
      RESPOND: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = refill_data_i;
        rsp_error_o = refill_error_i;
        rsp_id_o    = cur_entry.mask;
        if (rsp_ready_i) begin
          refill_rsp_ready_o = 1'b1;
          do_free            = 1'b1;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rid_q    <= '0;
      victim_q <= '0;
      for (int unsigned i = 0; i < PENDING_COUNT; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && refill_rsp_valid_i) rid_q <= refill_id_i;
      if (victim_adv) victim_q <= (victim_q == VICTIM_LAST) ? '0 : victim_q + 1'b1;
      for (int unsigned i = 0; i < PENDING_COUNT; i++) begin
        if (do_alloc && (free_idx == RID_W'(i))) begin
          entries_q[i].valid <= 1'b1;
          entries_q[i].line  <= line_in;
          entries_q[i].mask  <= in_id_i;
        end else if (do_free && (rid_q == RID_W'(i))) begin
          entries_q[i].valid <= 1'b0;
          entries_q[i].mask  <= '0;
        end else if (do_merge && match_vec[i]) begin
          entries_q[i].mask <= entries_q[i].mask | in_id_i;
        end
      end
    end
  end

  // A refill response for an entry that is not pending has no waiter; it is
  // drained silently, but it indicates a protocol problem upstream.
  a_refill_id_pending: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == IDLE && refill_rsp_valid_i) |-> valid_vec[refill_id_i]);

endmodule

// File: tb/tb_snitch_icache_refill_handler.sv
// Directed bench for the refill handler: a vector table for the single-cycle
// lookup paths plus hand-written refill sequences.
module tb_snitch_icache_refill_handler;
  import snitch_icache_pkg::*;

  localparam config_t TB_CFG = '{
    LINE_WIDTH: 128, LINE_COUNT: 8, SET_COUNT: 2, FETCH_AW: 32, ID_WIDTH_REQ: 4,
    default: 0
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_valid, flush_ready;
  logic [31:0]  in_addr;
  logic [3:0]   in_id;
  logic [0:0]   in_set;
  logic         in_hit, in_error, in_valid, in_ready;
  logic [127:0] in_data;
  logic [127:0] rsp_data;
  logic         rsp_error, rsp_valid, rsp_ready;
  logic [3:0]   rsp_id;
  logic [2:0]   write_addr;
  logic [0:0]   write_set;
  logic [127:0] write_data;
  logic [24:0]  write_tag;
  logic         write_error, write_valid, write_ready;
  logic [31:0]  refill_addr;
  logic [0:0]   refill_id;
  logic         refill_valid, refill_ready;
  logic [127:0] refill_data;
  logic         refill_error;
  logic [0:0]   refill_id_in;
  logic         refill_rsp_valid, refill_rsp_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snitch_icache_refill_handler #(
    .CFG           (TB_CFG),
    .PENDING_COUNT (2)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_valid_i      (flush_valid),
    .flush_ready_o      (flush_ready),
    .in_addr_i          (in_addr),
    .in_id_i            (in_id),
    .in_set_i           (in_set),
    .in_hit_i           (in_hit),
    .in_error_i         (in_error),
    .in_data_i          (in_data),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .rsp_data_o         (rsp_data),
    .rsp_error_o        (rsp_error),
    .rsp_id_o           (rsp_id),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .write_addr_o       (write_addr),
    .write_set_o        (write_set),
    .write_data_o       (write_data),
    .write_tag_o        (write_tag),
    .write_error_o      (write_error),
    .write_valid_o      (write_valid),
    .write_ready_i      (write_ready),
    .refill_addr_o      (refill_addr),
    .refill_id_o        (refill_id),
    .refill_valid_o     (refill_valid),
    .refill_ready_i     (refill_ready),
    .refill_data_i      (refill_data),
    .refill_error_i     (refill_error),
    .refill_id_i        (refill_id_in),
    .refill_rsp_valid_i (refill_rsp_valid),
    .refill_rsp_ready_o (refill_rsp_ready)
  );

  typedef struct {
    string        name;
    logic [31:0]  addr;
    logic [3:0]   id;
    logic         hit, err, valid, rdy;
    logic [127:0] data;
    logic         e_rsp_valid;
    logic [3:0]   e_rsp_id;
    logic         e_rsp_err;
    logic         e_in_ready;
    logic         e_refill_valid;
    logic [31:0]  e_refill_addr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic lookup(input logic v, input logic [31:0] a, input logic [3:0] id, input logic hit);
    in_valid = v;
    in_addr  = a;
    in_id    = id;
    in_hit   = hit;
    in_error = 1'b0;
  endtask

  task automatic refill_rsp(input logic v, input logic [0:0] id, input logic [127:0] d);
    refill_rsp_valid = v;
    refill_id_in     = id;
    refill_data      = d;
    refill_error     = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"hit_basic", 32'h0000_0100, 4'b0010, 1, 0, 1, 1, 128'hA5A5_0001_0203_0405_0607_0809_0A0B_0C0D,
                1, 4'b0010, 0, 1, 0, 32'h0000_0100};
    vecs[1] = '{"hit_stall", 32'h0000_0104, 4'b1000, 1, 0, 1, 0, 128'h1111_2222_3333_4444_5555_6666_7777_8888,
                1, 4'b1000, 0, 0, 0, 32'h0000_0100};
    vecs[2] = '{"hit_error", 32'h0000_02A8, 4'b0011, 0, 1, 1, 1, 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D,
                1, 4'b0011, 1, 1, 0, 32'h0000_02A0};
    vecs[3] = '{"miss_1234", 32'h0000_1234, 4'b0001, 0, 0, 1, 1, 128'h0,
                0, 4'b0000, 0, 0, 1, 32'h0000_1230};
    vecs[4] = '{"miss_top", 32'hFFFF_FFFF, 4'b0100, 0, 0, 1, 1, 128'h0,
                0, 4'b0000, 0, 0, 1, 32'hFFFF_FFF0};
    vecs[5] = '{"no_valid", 32'h0000_0040, 4'b0001, 0, 0, 0, 1, 128'h0,
                0, 4'b0000, 0, 0, 0, 32'h0000_0040};

    rst = 1'b1; flush_valid = 1'b0; in_set = '0; in_data = '0;
    lookup(0, 32'h0, 4'h0, 0);
    rsp_ready = 1'b0; write_ready = 1'b0; refill_ready = 1'b0;
    refill_rsp(0, 1'b0, '0);
    repeat (2) tick();
    rst = 1'b0;
    settle();

    // reset state
    chk("rst_flush_ready", flush_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_write_valid", write_valid, 0);
    chk("rst_refill_valid", refill_valid, 0);
    chk("rst_refill_rsp_ready", refill_rsp_ready, 0);

    // single-cycle lookup paths, nothing allocated (refill_ready low)
    for (int i = 0; i < 6; i++) begin
      lookup(vecs[i].valid, vecs[i].addr, vecs[i].id, vecs[i].hit);
      in_error  = vecs[i].err;
      in_data   = vecs[i].data;
      rsp_ready = vecs[i].rdy;
      settle();
      chk({vecs[i].name, "_rsp_valid"}, rsp_valid, vecs[i].e_rsp_valid);
      chk({vecs[i].name, "_in_ready"}, in_ready, vecs[i].e_in_ready);
      chk({vecs[i].name, "_refill_valid"}, refill_valid, vecs[i].e_refill_valid);
      chk({vecs[i].name, "_refill_addr"}, refill_addr, vecs[i].e_refill_addr);
      if (vecs[i].e_rsp_valid) begin
        chk({vecs[i].name, "_rsp_id"}, rsp_id, vecs[i].e_rsp_id);
        chk({vecs[i].name, "_rsp_data"}, rsp_data, vecs[i].data);
        chk({vecs[i].name, "_rsp_error"}, rsp_error, vecs[i].e_rsp_err);
      end
      if (vecs[i].e_refill_valid) chk({vecs[i].name, "_refill_id"}, refill_id, 0);
      tick();
    end
    lookup(0, 32'h0, 4'h0, 0);
    rsp_ready = 1'b0;
    in_data   = '0;

    // single miss, refill, write, respond; flush held throughout
    lookup(1, 32'h0000_1234, 4'b0001, 0);
    refill_ready = 1'b1;
    settle();
    chk("a_refill_valid", refill_valid, 1);
    chk("a_refill_addr", refill_addr, 32'h0000_1230);
    chk("a_refill_id", refill_id, 0);
    chk("a_in_ready", in_ready, 1);
    tick();
    lookup(0, 32'h0, 4'h0, 0);
    refill_ready = 1'b0;
    flush_valid  = 1'b1;
    refill_rsp(1, 1'b0, 128'hD0D0_0000_1111_2222_3333_4444_5555_6666);
    settle();
    chk("a_flush_pending", flush_ready, 0);
    chk("a_rsp_ready_idle", refill_rsp_ready, 0);
    tick();
    chk("a_write_valid", write_valid, 1);
    chk("a_write_addr", write_addr, 3);
    chk("a_write_tag", write_tag, 25'h24);
    chk("a_write_set", write_set, 0);
    chk("a_write_data", write_data, 128'hD0D0_0000_1111_2222_3333_4444_5555_6666);
    chk("a_flush_write", flush_ready, 0);
    lookup(1, 32'h0000_5000, 4'b0010, 0);
    refill_ready = 1'b1;
    settle();
    chk("a_flush_blocks_refill", refill_valid, 0);
    chk("a_flush_blocks_ready", in_ready, 0);
    lookup(0, 32'h0, 4'h0, 0);
    refill_ready = 1'b0;
    tick();
    chk("a_write_hold", write_valid, 1);
    write_ready = 1'b1;
    tick();
    write_ready = 1'b0;
    settle();
    chk("a_rsp_valid", rsp_valid, 1);
    chk("a_rsp_id", rsp_id, 4'b0001);
    chk("a_rsp_data", rsp_data, 128'hD0D0_0000_1111_2222_3333_4444_5555_6666);
    chk("a_write_done", write_valid, 0);
    chk("a_refill_rsp_ready_hold", refill_rsp_ready, 0);
    chk("a_flush_respond", flush_ready, 0);
    rsp_ready = 1'b1;
    settle();
    chk("a_refill_rsp_ready", refill_rsp_ready, 1);
    tick();
    refill_rsp(0, 1'b0, '0);
    rsp_ready = 1'b0;
    settle();
    chk("a_flush_ready_after", flush_ready, 1);
    chk("a_rsp_valid_after", rsp_valid, 0);
    flush_valid = 1'b0;

    // two misses to one line merge into a single refill
    lookup(1, 32'h0000_1230, 4'b0001, 0);
    refill_ready = 1'b1;
    settle();
    chk("b_refill_valid", refill_valid, 1);
    tick();
    lookup(1, 32'h0000_123C, 4'b0100, 0);
    settle();
    chk("b_merge_no_refill", refill_valid, 0);
    chk("b_merge_in_ready", in_ready, 1);
    tick();
    lookup(0, 32'h0, 4'h0, 0);
    refill_ready = 1'b0;
    refill_rsp(1, 1'b0, 128'hBBBB_0000_0000_0000_0000_0000_0000_BBBB);
    write_ready = 1'b1;
    rsp_ready   = 1'b1;
    tick();
    chk("b_write_set", write_set, 1);
    chk("b_write_addr", write_addr, 3);
    tick();
    chk("b_rsp_id", rsp_id, 4'b0101);
    chk("b_rsp_data", rsp_data, 128'hBBBB_0000_0000_0000_0000_0000_0000_BBBB);
    tick();
    refill_rsp(0, 1'b0, '0);

    // table full: third distinct miss waits for the first completion
    lookup(1, 32'h0000_2000, 4'b0001, 0);
    refill_ready = 1'b1;
    settle();
    chk("c_first_id", refill_id, 0);
    tick();
    lookup(1, 32'h0000_3000, 4'b0010, 0);
    settle();
    chk("c_second_id", refill_id, 1);
    tick();
    lookup(1, 32'h0000_4000, 4'b0100, 0);
    settle();
    chk("c_full_in_ready", in_ready, 0);
    chk("c_full_refill_valid", refill_valid, 0);
    refill_rsp(1, 1'b0, 128'hC0);
    tick();
    chk("c_write_set_wrap", write_set, 0);
    chk("c_write_tag", write_tag, 25'h40);
    chk("c_full_in_ready_write", in_ready, 0);
    tick();
    chk("c_full_in_ready_respond", in_ready, 0);
    chk("c_rsp_id0", rsp_id, 4'b0001);
    tick();
    refill_rsp(0, 1'b0, '0);
    settle();
    chk("c_third_in_ready", in_ready, 1);
    chk("c_third_refill_valid", refill_valid, 1);
    chk("c_third_refill_id", refill_id, 0);
    chk("c_third_refill_addr", refill_addr, 32'h0000_4000);
    tick();
    lookup(0, 32'h0, 4'h0, 0);
    refill_ready = 1'b0;
    refill_rsp(1, 1'b1, 128'hC1);
    tick();
    chk("c_write_set_e1", write_set, 1);
    chk("c_write_tag_e1", write_tag, 25'h60);
    tick();
    chk("c_rsp_id1", rsp_id, 4'b0010);
    chk("c_rsp_data1", rsp_data, 128'hC1);
    tick();
    refill_rsp(1, 1'b0, 128'hC2);
    tick();
    chk("c_write_set_e0", write_set, 0);
    chk("c_write_tag_e0", write_tag, 25'h80);
    tick();
    chk("c_rsp_id2", rsp_id, 4'b0100);
    tick();
    refill_rsp(0, 1'b0, '0);
    settle();
    chk("c_flush_ready_idle", flush_ready, 1);

    // reset while a refill is being written drops everything
    write_ready = 1'b0;
    rsp_ready   = 1'b0;
    lookup(1, 32'h0000_6000, 4'b1000, 0);
    refill_ready = 1'b1;
    tick();
    lookup(0, 32'h0, 4'h0, 0);
    refill_ready = 1'b0;
    refill_rsp(1, 1'b0, 128'hE0);
    tick();
    chk("d_write_before_rst", write_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    refill_rsp(0, 1'b0, '0);
    settle();
    chk("d_write_valid", write_valid, 0);
    chk("d_rsp_valid", rsp_valid, 0);
    chk("d_flush_ready", flush_ready, 1);
    chk("d_victim_reset", write_set, 0);
    lookup(1, 32'h0000_6000, 4'b0001, 0);
    refill_ready = 1'b1;
    settle();
    chk("d_no_stale_merge", refill_valid, 1);
    chk("d_fresh_id", refill_id, 0);
    lookup(0, 32'h0, 4'h0, 0);
    refill_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
